uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx byte transmitter between N_REQ byte requesters (e.g. the document
//  dumper plus a status/debug reporter). Round-robin arbitration per byte; frame lock keeps
//  a SIGACK..SIGEOF frame from one requester contiguous. Sits between requesters and uart_tx.
// PARAMETERS
//  N_REQ         2             number of requesters (2..8)
//  SIGACK        8'hCC         frame-start byte; when sent, locks arbiter to its sender
//  SIGEOF        8'hDD         frame-end byte; when sent, releases the lock
//  LOCK_TIMEOUT  20'd1000000   idle-owner cycles before forced unlock (ARB_LOCK_TIMEOUT_EN only)
// PORTS
//  clk            in   1          system clock (100 MHz)
//  reset          in   1          asynchronous, active-high reset
//  req_valid      in   N_REQ      per-requester byte valid; held with data until req_ack
//  req_data       in   8*N_REQ    byte i at [8*i+7:8*i]
//  req_ack        out  N_REQ      one-cycle pulse: byte of requester i taken
//  tx_ready       in   1          from uart_tx; 1 = transmitter idle
//  tx_data_valid  out  1          to uart_tx; one-cycle issue strobe
//  tx_data        out  8          to uart_tx; byte being issued
//  grant_id       out  $clog2(N_REQ)  index of last/current granted requester
//  locked         out  1          frame lock active
//  lock_timeout   out  1          one-cycle pulse on forced unlock (0 without macro)
// BEHAVIOUR
//  - Reset (async): state S_IDLE; req_ack=0, tx_data_valid=0, tx_data=0, grant_id=N_REQ-1
//    (so requester 0 has first priority), locked=0, lock_timeout=0, timeout counter=0.
//  - States: S_IDLE -> S_ISSUE -> S_WAIT -> S_IDLE. All outputs registered.
//  - S_IDLE: if tx_ready=1 and eligible request exists: pick winner, latch byte into tx_data,
//    grant_id<=winner, pulse req_ack[winner] this same cycle (registered: visible next cycle
//    together with tx_data_valid), go S_ISSUE. Eligible = all valid reqs when unlocked, only
//    req_valid[grant_id] when locked. tx_ready=0 in S_IDLE: stay, no ack.
//  - Round-robin: search starts at grant_id+1 mod N_REQ, first valid wins.
//  - S_ISSUE: tx_data_valid=1 exactly one cycle; req_ack[grant_id]=1 exactly one cycle.
//    Lock update: byte==SIGACK -> locked<=1; byte==SIGEOF -> locked<=0; else unchanged.
//    Go S_WAIT. Requester may change req_data/req_valid from the cycle after req_ack.
//  - S_WAIT: ignore first cycle (uart_tx drops tx_ready one cycle after strobe); thereafter
//    return to S_IDLE on tx_ready=1. Min byte-to-byte spacing: 3 cycles + uart frame time.
//  - Boundaries: SIGACK while already locked by owner -> stays locked; SIGEOF while unlocked
//    -> no effect; req_valid dropped before ack -> request withdrawn, no ack; simultaneous
//    requests -> exactly one ack per issued byte, never two acks in one cycle.
//  - Reset mid-frame: lock and any pending byte discarded; uart_tx is reset by same signal.
//  - Data bytes are passed unmodified (no ASCII bias applied here).
// CONFIGURATION
//  ARB_LOCK_TIMEOUT_EN defined: while locked and in S_IDLE with req_valid[grant_id]=0, a
//    20-bit counter increments; reaching LOCK_TIMEOUT -> locked<=0, counter<=0, lock_timeout
//    pulses 1 cycle. Counter clears on any owner byte issue or when unlocked.
//  Not defined: no counter; lock held until SIGEOF or reset; lock_timeout tied 0.
// TESTING
//  1 Reset: assert reset mid-S_WAIT -> all outputs 0, grant_id=N_REQ-1, locked=0 immediately.
//  2 Single req: req0 valid 8'h41 -> req_ack[0] then tx_data_valid with tx_data=8'h41, 1 cycle.
//  3 Round-robin: req0,req1 held valid (non-SIGACK) -> issue order 0,1,0,1; one ack per byte.
//  4 Frame lock: req1 sends CC,48,49,DD while req0 valid -> no req0 ack until after DD issued.
//  5 Backpressure: tx_ready=0 held 500 cycles in S_IDLE -> no ack, no strobe; data stable.
//  6 Timeout (macro, LOCK_TIMEOUT=20'd100): req0 sends CC then idles -> lock_timeout pulse
//    after 100 idle cycles, then req1 granted; without macro req1 starved until DD.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter sharing one uart_tx between N_REQ requesters, with SIGACK..SIGEOF frame lock.
// Optional idle-owner forced unlock is compiled in with `define ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int          N_REQ        = 2,
  parameter logic [7:0]  SIGACK       = 8'hCC,
  parameter logic [7:0]  SIGEOF       = 8'hDD,
  parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ack,
  input  logic                     tx_ready,
  output logic                     tx_data_valid,
  output logic [7:0]               tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked,
  output logic                     lock_timeout
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] req_ack_q;
  logic             tx_valid_q;
  logic [7:0]       tx_data_q;
  logic [GW-1:0]    grant_q;
  logic             locked_q;
  logic             wait_first_q;

  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] eligible;
  logic             win_found_d;
  logic [GW-1:0]    grant_d;
  logic [7:0]       win_byte_d;

  // Winner search starts one past the last grant; when locked only the owner is eligible.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    owner_mask           = '0;
    owner_mask[grant_q]  = 1'b1;
    eligible             = locked_q ? (req_valid & owner_mask) : req_valid;
    win_found_d          = 1'b0;
    grant_d              = grant_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!win_found_d && eligible[(int'(grant_q) + k) % N_REQ]) begin
        win_found_d = 1'b1;
        grant_d     = GW'((int'(grant_q) + k) % N_REQ);
      end
    end
    win_byte_d = req_data[{grant_d, 3'b000} +: 8];
  end

`ifdef ARB_LOCK_TIMEOUT_EN
  logic [19:0] to_cnt_q;
  logic        lock_to_q;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      req_ack_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      grant_q      <= GW'(N_REQ - 1);
      locked_q     <= 1'b0;
      wait_first_q <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
      to_cnt_q     <= '0;
      lock_to_q    <= 1'b0;
`endif
    end else begin
      req_ack_q  <= '0;
      tx_valid_q <= 1'b0;
`ifdef ARB_LOCK_TIMEOUT_EN
      lock_to_q  <= 1'b0;
      if (!locked_q) to_cnt_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (tx_ready && win_found_d) begin
            req_ack_q[grant_d] <= 1'b1;
            tx_valid_q         <= 1'b1;
            tx_data_q          <= win_byte_d;
            grant_q            <= grant_d;
            state_q            <= S_ISSUE;
          end
`ifdef ARB_LOCK_TIMEOUT_EN
          if (locked_q && !req_valid[grant_q]) begin
            if (to_cnt_q == LOCK_TIMEOUT - 20'd1) begin
              locked_q  <= 1'b0;
              to_cnt_q  <= '0;
              lock_to_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 20'd1;
            end
          end
`endif
        end
        S_ISSUE: begin
          if (tx_data_q == SIGACK)      locked_q <= 1'b1;
          else if (tx_data_q == SIGEOF) locked_q <= 1'b0;
          wait_first_q <= 1'b1;
          state_q      <= S_WAIT;
`ifdef ARB_LOCK_TIMEOUT_EN
          to_cnt_q     <= '0;
`endif
        end
        S_WAIT: begin
          // uart_tx still shows ready in the first cycle after the strobe.
          if (wait_first_q)  wait_first_q <= 1'b0;
          else if (tx_ready) state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack       = req_ack_q;
  assign tx_data_valid = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign grant_id      = grant_q;
  assign locked        = locked_q;
`ifdef ARB_LOCK_TIMEOUT_EN
  assign lock_timeout  = lock_to_q;
`else
  assign lock_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-driven requesters, a simple uart_tx ready model,
// and a list-based round-robin/frame-lock reference for randomized traffic.
module tb_uart_tx_arbiter;
  localparam int         N     = 2;
  localparam logic [7:0] ACK_B = 8'hCC;
  localparam logic [7:0] EOF_B = 8'hDD;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           tx_ready;
  logic           tx_data_valid;
  logic [7:0]     tx_data;
  logic [0:0]     grant_id;
  logic           locked;
  logic           lock_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .SIGACK(ACK_B), .SIGEOF(EOF_B), .LOCK_TIMEOUT(20'd100)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_ready(tx_ready), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .grant_id(grant_id), .locked(locked), .lock_timeout(lock_timeout)
  );

  logic [7:0] rq [N][$];
  int         issued_id [$];
  logic [7:0] issued_data [$];
  bit         lock_hist [$];
  int         proto_err, to_pulses, busy;
  bit         prev_valid, uart_hold;
  int         total = 0, passed = 0;

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rq[i].size() > 0);
      req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  // One clock: sample outputs at the falling edge, then update requesters and the uart model.
  task automatic step();
    logic [N-1:0] one_hot;
    @(negedge clk);
    one_hot           = '0;
    one_hot[grant_id] = 1'b1;
    if (tx_data_valid) begin
      issued_id.push_back(int'(grant_id));
      issued_data.push_back(tx_data);
      if (req_ack !== one_hot) proto_err++;
      if (prev_valid) proto_err++;
    end else if (req_ack !== '0) begin
      proto_err++;
    end
    if (prev_valid) lock_hist.push_back(locked);
    if (lock_timeout) to_pulses++;
    prev_valid = tx_data_valid;
    for (int i = 0; i < N; i++)
      if (req_ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    if (tx_data_valid) begin
      busy     = $urandom_range(1, 6);
      tx_ready = 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) tx_ready = !uart_hold;
    end else begin
      tx_ready = !uart_hold;
    end
    drive_reqs();
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) rq[i].delete();
    issued_id.delete();
    issued_data.delete();
    lock_hist.delete();
    proto_err  = 0;
    to_pulses  = 0;
    busy       = 0;
    prev_valid = 1'b0;
    uart_hold  = 1'b0;
    tx_ready   = 1'b1;
    drive_reqs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_tb();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int c = 0;
    while (issued_data.size() < n && c < budget) begin
      step();
      c++;
    end
    ok = (issued_data.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_tb();
    repeat (3) @(negedge clk);
    total++; if ({req_ack, tx_data_valid, tx_data, locked, lock_timeout} !== 12'h000)
      $display("FAIL reset_outputs: got ack=%b v=%b d=%h lk=%b to=%b, want all 0",
               req_ack, tx_data_valid, tx_data, locked, lock_timeout); else passed++;
    total++; if (grant_id !== 1'b1)
      $display("FAIL reset_grant: got %0d want %0d", grant_id, N - 1); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    rq[1].push_back(ACK_B);
    drive_reqs();
    run_until(1, 40, ok);
    total++; if (!ok) $display("FAIL midwait_issue: no strobe within 40 cycles"); else passed++;
    step();
    total++; if (locked !== 1'b1) $display("FAIL midwait_locked: got %b want 1", locked); else passed++;
    reset = 1'b1;
    #1;
    total++; if ({req_ack, tx_data_valid, tx_data, locked, lock_timeout, grant_id} !== 13'h0001)
      $display("FAIL midwait_async_reset: got ack=%b v=%b d=%h lk=%b to=%b g=%0d, want 0s and g=1",
               req_ack, tx_data_valid, tx_data, locked, lock_timeout, grant_id); else passed++;
    clear_tb();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    rq[0].push_back(8'h41);
    drive_reqs();
    run_until(1, 40, ok);
    repeat (10) step();
    total++; if (!ok || issued_data.size() != 1)
      $display("FAIL single_count: got %0d strobes want 1", issued_data.size()); else passed++;
    total++; if (ok && (issued_id[0] != 0 || issued_data[0] !== 8'h41))
      $display("FAIL single_byte: got id=%0d d=%h want id=0 d=41", issued_id[0], issued_data[0]); else passed++;
    total++; if (proto_err != 0) $display("FAIL single_protocol: got %0d errors want 0", proto_err); else passed++;
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rq[0].push_back(8'h10 + 8'(k));
      rq[1].push_back(8'h20 + 8'(k));
    end
    drive_reqs();
    run_until(8, 200, ok);
    total++; if (!ok) $display("FAIL rr_count: got %0d strobes want 8", issued_data.size()); else passed++;
    for (int k = 0; k < issued_data.size() && k < 8; k++) begin
      total++; if (issued_id[k] != k % 2 || issued_data[k] !== 8'(8'h10 * (k % 2 + 1) + k / 2))
        $display("FAIL rr_order[%0d]: got id=%0d d=%h want id=%0d d=%h", k, issued_id[k],
                 issued_data[k], k % 2, 8'(8'h10 * (k % 2 + 1) + k / 2)); else passed++;
    end
    total++; if (proto_err != 0) $display("FAIL rr_protocol: got %0d errors want 0", proto_err); else passed++;
  endtask

  task automatic test_frame_lock();
    bit ok;
    int         exp_id [6]   = '{1, 1, 1, 1, 0, 0};
    logic [7:0] exp_d  [6]   = '{ACK_B, 8'h48, 8'h49, EOF_B, 8'h30, 8'h31};
    bit         exp_lk [6]   = '{1, 1, 1, 0, 0, 0};
    do_reset();
    rq[1] = '{ACK_B, 8'h48, 8'h49, EOF_B};
    drive_reqs();
    run_until(1, 40, ok);
    rq[0] = '{8'h30, 8'h31};
    drive_reqs();
    run_until(6, 300, ok);
    repeat (3) step();
    total++; if (!ok) $display("FAIL lock_count: got %0d strobes want 6", issued_data.size()); else passed++;
    for (int k = 0; k < 6 && k < issued_data.size(); k++) begin
      total++; if (issued_id[k] != exp_id[k] || issued_data[k] !== exp_d[k])
        $display("FAIL lock_order[%0d]: got id=%0d d=%h want id=%0d d=%h", k, issued_id[k],
                 issued_data[k], exp_id[k], exp_d[k]); else passed++;
    end
    for (int k = 0; k < 6 && k < lock_hist.size(); k++) begin
      total++; if (lock_hist[k] !== exp_lk[k])
        $display("FAIL lock_state[%0d]: got %b want %b", k, lock_hist[k], exp_lk[k]); else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad = 0;
    do_reset();
    uart_hold = 1'b1;
    tx_ready  = 1'b0;
    rq[0].push_back(8'h5A);
    drive_reqs();
    for (int c = 0; c < 500; c++) begin
      step();
      if (tx_data_valid || req_ack !== '0 || tx_data !== 8'h00) bad++;
    end
    total++; if (bad != 0 || issued_data.size() != 0)
      $display("FAIL bp_hold: got %0d bad cycles, %0d strobes, want 0", bad, issued_data.size()); else passed++;
    uart_hold = 1'b0;
    run_until(1, 20, ok);
    total++; if (!ok || issued_data[0] !== 8'h5A)
      $display("FAIL bp_release: got %0d strobes, want one with d=5A", issued_data.size()); else passed++;
  endtask

  task automatic test_withdraw();
    do_reset();
    uart_hold = 1'b1;
    tx_ready  = 1'b0;
    rq[0].push_back(8'h66);
    drive_reqs();
    repeat (5) step();
    rq[0].delete();
    drive_reqs();
    uart_hold = 1'b0;
    repeat (30) step();
    total++; if (issued_data.size() != 0 || proto_err != 0)
      $display("FAIL withdraw: got %0d strobes %0d proto errors, want 0", issued_data.size(), proto_err); else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int c = 0;
    do_reset();
    rq[0].push_back(ACK_B);
    drive_reqs();
    run_until(1, 40, ok);
    rq[1].push_back(8'h77);
    drive_reqs();
`ifdef ARB_LOCK_TIMEOUT_EN
    while (to_pulses == 0 && c < 300) begin
      step();
      c++;
    end
    total++; if (to_pulses != 1 || c < 100 || c > 115)
      $display("FAIL timeout_pulse: got pulse after %0d cycles (pulses=%0d), want 1 in 100..115", c, to_pulses); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL timeout_unlock: got locked=%b want 0", locked); else passed++;
    run_until(2, 20, ok);
    step();
    total++; if (!ok || issued_id[1] != 1 || issued_data[1] !== 8'h77)
      $display("FAIL timeout_next: got %0d strobes, want req1 byte 77 second", issued_data.size()); else passed++;
    total++; if (to_pulses != 1) $display("FAIL timeout_width: got %0d pulse cycles want 1", to_pulses); else passed++;
`else
    for (c = 0; c < 300; c++) step();
    total++; if (issued_data.size() != 1 || locked !== 1'b1 || to_pulses != 0)
      $display("FAIL starve: got %0d strobes locked=%b pulses=%0d, want 1, 1, 0",
               issued_data.size(), locked, to_pulses); else passed++;
    rq[0].push_back(EOF_B);
    drive_reqs();
    run_until(3, 60, ok);
    total++; if (!ok || issued_id[1] != 0 || issued_data[1] !== EOF_B || issued_id[2] != 1 || issued_data[2] !== 8'h77)
      $display("FAIL starve_release: got %0d strobes, want DD from 0 then 77 from 1", issued_data.size()); else passed++;
`endif
  endtask

  function automatic logic [7:0] plain_byte();
    logic [7:0] b;
    do b = 8'($urandom); while (b == ACK_B || b == EOF_B);
    return b;
  endfunction

  task automatic test_random();
    bit ok;
    logic [7:0] m [N][$];
    int         exp_id [$];
    logic [7:0] exp_d [$];
    int         last, w;
    bit         lk;
    logic [7:0] b;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(2, 5)) begin
          if ($urandom_range(0, 2) == 0) begin
            rq[i].push_back(ACK_B);
            if ($urandom_range(0, 3) == 0) rq[i].push_back(ACK_B);
            repeat ($urandom_range(1, 3)) rq[i].push_back(plain_byte());
            rq[i].push_back(EOF_B);
          end else begin
            rq[i].push_back(($urandom_range(0, 7) == 0) ? EOF_B : plain_byte());
          end
        end
        m[i] = rq[i];
      end
      exp_id.delete();
      exp_d.delete();
      last = N - 1;
      lk   = 1'b0;
      while (m[0].size() + m[1].size() > 0) begin
        w = last;
        if (!lk)
          for (int k = N; k >= 1; k--) if (m[(last + k) % N].size() > 0) w = (last + k) % N;
        b = m[w].pop_front();
        exp_id.push_back(w);
        exp_d.push_back(b);
        if (b == ACK_B) lk = 1'b1;
        else if (b == EOF_B) lk = 1'b0;
        last = w;
      end
      drive_reqs();
      run_until(exp_d.size(), 3000, ok);
      repeat (10) step();
      total++; if (!ok || issued_data.size() != exp_d.size())
        $display("FAIL rand%0d_count: got %0d strobes want %0d", it, issued_data.size(), exp_d.size()); else passed++;
      for (int k = 0; k < exp_d.size() && k < issued_data.size(); k++) begin
        total++; if (issued_id[k] != exp_id[k] || issued_data[k] !== exp_d[k])
          $display("FAIL rand%0d_byte[%0d]: got id=%0d d=%h want id=%0d d=%h", it, k,
                   issued_id[k], issued_data[k], exp_id[k], exp_d[k]); else passed++;
      end
      total++; if (proto_err != 0 || to_pulses != 0 || locked !== 1'b0)
        $display("FAIL rand%0d_protocol: got err=%0d pulses=%0d locked=%b want 0,0,0",
                 it, proto_err, to_pulses, locked); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_single();
    test_round_robin();
    test_frame_lock();
    test_backpressure();
    test_withdraw();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
